// File: rtl/cpu_pkg.sv
// Shared types for the store write buffer: default widths, drain FSM encoding, entry layout.
package cpu_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    SWB_IDLE = 1'b0,
    SWB_BUSY = 1'b1
  } swb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } swb_entry_t;

endpackage

// File: rtl/swb_fifo_mem.sv
// Store buffer storage: entry array with valid bits, read/write pointers and occupancy count.
module swb_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  logic [ADDR_W-1:0]                push_addr,
  input  logic [DATA_W-1:0]                push_data,
  input  logic                             pop,
  output logic [ADDR_W-1:0]                head_addr,
  output logic [DATA_W-1:0]                head_data,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]     ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]     ent_data,
  output logic [$clog2(DEPTH)-1:0]         wptr,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rptr;

  // Push and pop never target the same slot: pop needs an entry, push needs a free one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        mem[rptr].valid <= 1'b0;
        rptr            <= rptr + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_comb begin
    head_addr = mem[rptr].addr;
    head_data = mem[rptr].data;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = mem[i].valid;
      ent_addr[i]  = mem[i].addr;
      ent_data[i]  = mem[i].data;
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer from ROB store commit to the dcache write port, drained in order.
// Load forwarding is built only when STORE_FWD_EN is defined; otherwise hit/data read 0.
module store_write_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       robWriteEnable,
  input  logic [ADDR_W-1:0]          robWriteAddr,
  input  logic [DATA_W-1:0]          robWriteData,
  output logic                       robWriteDone,
  output logic                       cacheWriteEnable,
  output logic [ADDR_W-1:0]          cacheWriteAddr,
  output logic [DATA_W-1:0]          cacheWriteData,
  input  logic                       cacheWriteDone,
  input  logic [ADDR_W-1:0]          loadAddr,
  output logic                       loadFwdHit,
  output logic [DATA_W-1:0]          loadFwdData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  swb_state_t                  state, state_nxt;
  logic                        push, pop, load;
  logic [ADDR_W-1:0]           head_addr;
  logic [DATA_W-1:0]           head_data;
  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PTR_W-1:0]            wptr;

  swb_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_addr (robWriteAddr),
    .push_data (robWriteData),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .wptr      (wptr),
    .count     (count)
  );

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // The done term keeps a still-held enable from being accepted twice.
  assign push  = robWriteEnable && !full && !robWriteDone;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) robWriteDone <= 1'b0;
    else        robWriteDone <= push;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= SWB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SWB_IDLE: if (!empty)        state_nxt = SWB_BUSY;
      SWB_BUSY: if (cacheWriteDone) state_nxt = SWB_IDLE;
      default:                      state_nxt = SWB_IDLE;
    endcase
  end

  always_comb begin
    cacheWriteEnable = (state == SWB_BUSY);
    load             = (state == SWB_IDLE) && !empty;
    pop              = (state == SWB_BUSY) && cacheWriteDone;
  end

  // Head is copied out at launch so the cache sees stable values for the whole request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cacheWriteAddr <= '0;
      cacheWriteData <= '0;
    end else if (load) begin
      cacheWriteAddr <= head_addr;
      cacheWriteData <= head_data;
    end
  end

`ifdef STORE_FWD_EN
  // Oldest-to-youngest walk so the last match, the youngest store, wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    loadFwdHit  = 1'b0;
    loadFwdData = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = wptr - PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == loadAddr)) begin
        loadFwdHit  = 1'b1;
        loadFwdData = ent_data[idx];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd  = ^{loadAddr, ent_valid, ent_addr, ent_data, wptr};
  assign loadFwdHit  = 1'b0;
  assign loadFwdData = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: reset, single store, fill/full, ordering with wrap, forwarding, async reset.
module tb_store_write_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        robWriteEnable = 1'b0;
  logic [31:0] robWriteAddr = '0;
  logic [31:0] robWriteData = '0;
  logic        robWriteDone;
  logic        cacheWriteEnable;
  logic [31:0] cacheWriteAddr;
  logic [31:0] cacheWriteData;
  logic        cacheWriteDone;
  logic [31:0] loadAddr = '0;
  logic        loadFwdHit;
  logic [31:0] loadFwdData;
  logic        full, empty;
  logic [2:0]  count;

  logic ack_man  = 1'b0;
  logic ack_auto = 1'b0;
  logic auto_ack = 1'b0;
  bit   pend     = 1'b0;
  int   cd       = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  int total = 0;
  int bad   = 0;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  assign cacheWriteDone = ack_man | ack_auto;

  store_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .robWriteEnable   (robWriteEnable),
    .robWriteAddr     (robWriteAddr),
    .robWriteData     (robWriteData),
    .robWriteDone     (robWriteDone),
    .cacheWriteEnable (cacheWriteEnable),
    .cacheWriteAddr   (cacheWriteAddr),
    .cacheWriteData   (cacheWriteData),
    .cacheWriteDone   (cacheWriteDone),
    .loadAddr         (loadAddr),
    .loadFwdHit       (loadFwdHit),
    .loadFwdData      (loadFwdData),
    .full             (full),
    .empty            (empty),
    .count            (count)
  );

  always #5 clock = ~clock;

  // Cache model: logs each launched write, acknowledges 1-3 cycles later.
  always begin
    @(posedge clock);
    #1;
    ack_auto = 1'b0;
    if (auto_ack) begin
      if (pend) begin
        if (cd == 0) begin
          ack_auto = 1'b1;
          pend     = 1'b0;
        end else begin
          cd = cd - 1;
        end
      end else if (cacheWriteEnable) begin
        obs_q.push_back({cacheWriteAddr, cacheWriteData});
        pend = 1'b1;
        cd   = $urandom_range(0, 2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic commit(input logic [31:0] a, input logic [31:0] d, input int budget, output bit ok);
    robWriteEnable = 1'b1;
    robWriteAddr   = a;
    robWriteData   = d;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (robWriteDone) begin
        ok = 1'b1;
        break;
      end
    end
    robWriteEnable = 1'b0;
  endtask

  initial begin
    bit ok;

    // Reset state
    #2;
    check("rst_done", robWriteDone, 0);
    check("rst_cwe", cacheWriteEnable, 0);
    check("rst_caddr", cacheWriteAddr, 0);
    check("rst_cdata", cacheWriteData, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_hit", loadFwdHit, 0);
    #10 reset = 1'b1;

    // Single store
    commit(32'h40, 32'hDEADBEEF, 1, ok);
    check("s1_done", ok, 1);
    check("s1_count", count, 1);
    check("s1_cwe_early", cacheWriteEnable, 0);
    tick();
    check("s1_done_clr", robWriteDone, 0);
    check("s1_cwe", cacheWriteEnable, 1);
    check("s1_caddr", cacheWriteAddr, 32'h40);
    check("s1_cdata", cacheWriteData, 32'hDEADBEEF);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("s1_empty", empty, 1);
    check("s1_cwe_off", cacheWriteEnable, 0);

    // Fill to full with no cache acknowledge
    for (int k = 0; k < 4; k++) begin
      commit(32'(4 * k), 32'(4 * k) ^ 32'hA5A50000, 4, ok);
      check("fill_done", ok, 1);
    end
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    robWriteEnable = 1'b1;
    robWriteAddr   = 32'h10;
    robWriteData   = 32'h10 ^ 32'hA5A50000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_held", robWriteDone, 0);
    end
    check("full_head_addr", cacheWriteAddr, 32'h0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("pop_count", count, 3);
    check("pop_full", full, 0);
    check("pop_nodone", robWriteDone, 0);
    tick();
    robWriteEnable = 1'b0;
    check("fifth_done", robWriteDone, 1);
    check("fifth_count", count, 4);
    check("fifth_full", full, 1);
    check("next_cwe", cacheWriteEnable, 1);
    check("next_caddr", cacheWriteAddr, 32'h4);

    // Drain remainder, then stream 10 more stores through the wrapping pointers
    for (int k = 1; k < 5; k++)
      exp_q.push_back({32'(4 * k), 32'(4 * k) ^ 32'hA5A50000});
    auto_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      commit(32'h100 + 32'(4 * k), 32'h1000_0000 + 32'(k), 40, ok);
      check("wrap_done", ok, 1);
      exp_q.push_back({32'h100 + 32'(4 * k), 32'h1000_0000 + 32'(k)});
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (empty && !pend) begin
        ok = 1'b1;
        break;
      end
    end
    auto_ack = 1'b0;
    check("drain_done", ok, 1);
    check("order_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("order_item", (i < obs_q.size()) ? obs_q[i] : 64'hX, exp_q[i]);

    // Forwarding: youngest of two same-address stores
    commit(32'h80, 32'h1, 4, ok);
    check("fwd_c1", ok, 1);
    commit(32'h80, 32'h2, 4, ok);
    check("fwd_c2", ok, 1);
    loadAddr = 32'h80;
    #1;
    check("fwd_hit", loadFwdHit, FWD);
    check("fwd_data", loadFwdData, FWD ? 32'h2 : 32'h0);
    loadAddr = 32'h84;
    #1;
    check("fwd_miss", loadFwdHit, 0);
    check("fwd_miss_data", loadFwdData, 0);

    // Simultaneous push and pop at count=2
    tick();
    check("pp_busy", cacheWriteEnable, 1);
    check("pp_count0", count, 2);
    robWriteEnable = 1'b1;
    robWriteAddr   = 32'h90;
    robWriteData   = 32'h3;
    ack_man        = 1'b1;
    tick();
    robWriteEnable = 1'b0;
    ack_man        = 1'b0;
    check("pp_done", robWriteDone, 1);
    check("pp_count", count, 2);
    check("pp_cwe", cacheWriteEnable, 0);
    loadAddr = 32'h90;
    #1;
    check("pp_fwd_hit", loadFwdHit, FWD);
    check("pp_fwd_data", loadFwdData, FWD ? 32'h3 : 32'h0);

    // Async reset while BUSY
    tick();
    check("ar_busy", cacheWriteEnable, 1);
    check("ar_caddr", cacheWriteAddr, 32'h80);
    check("ar_cdata", cacheWriteData, 32'h2);
    #3 reset = 1'b0;
    #1;
    check("ar_cwe", cacheWriteEnable, 0);
    check("ar_count", count, 0);
    check("ar_empty", empty, 1);
    check("ar_caddr0", cacheWriteAddr, 0);
    #2 reset = 1'b1;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("ar_late_ack_count", count, 0);
    check("ar_late_ack_cwe", cacheWriteEnable, 0);
    tick();
    check("ar_idle_cwe", cacheWriteEnable, 0);
    check("ar_idle_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write buffer between reorder-buffer store commit and the data cache write port.
- Acts as the responder on the ROB commit handshake: it accepts the store, queues it, and returns the done pulse immediately. The ROB retires without waiting on the cache.
- Acts as the initiator on the cache write handshake: it drains entries in order, one outstanding cache write at a time.
- Sits in parallel with the load unit's cache read path, so queued stores stay visible to younger loads.

Parameters:
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- ADDR_W, 32: store address width.
- DATA_W, 32: store data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- robWriteEnable  input  1  commit request; level signal held until robWriteDone is seen.
- robWriteAddr  input  ADDR_W  committed store address.
- robWriteData  input  DATA_W  committed store data.
- robWriteDone  output  1  one-cycle accept pulse back to the ROB.
- cacheWriteEnable  output  1  cache write request; held until cacheWriteDone.
- cacheWriteAddr  output  ADDR_W  address of the head entry.
- cacheWriteData  output  DATA_W  data of the head entry.
- cacheWriteDone  input  1  one-cycle completion pulse from the cache.
- loadAddr  input  ADDR_W  address probed by the load unit.
- loadFwdHit  output  1  loadAddr matches a queued store.
- loadFwdData  output  DATA_W  data of the youngest matching entry.
- full  output  1  count equals DEPTH.
- empty  output  1  count equals 0.
- count  output  clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (reset low, asynchronous):
  - Pointers and count go to 0; all valid bits clear.
  - FSM goes to IDLE.
  - robWriteDone=0, cacheWriteEnable=0, cacheWriteAddr=0, cacheWriteData=0.
  - loadFwdHit=0, loadFwdData=0, empty=1, full=0.
  - Reset mid-drain abandons the in-flight cache write; a cacheWriteDone arriving after reset is ignored.
- Push:
  - Condition at a rising edge: robWriteEnable && !full && !robWriteDone.
  - Entry written at wptr; wptr increments modulo DEPTH.
  - robWriteDone is registered high for exactly the next cycle.
  - The !robWriteDone term blocks double-accept while the ROB lowers its enable; back-to-back commits therefore cost 2 cycles each.
- Full:
  - full is evaluated from the registered count only.
  - A push is refused while full even if a pop happens in the same cycle.
  - robWriteDone stays 0; the ROB keeps holding its request.
- Drain FSM, two states:
  - IDLE: if !empty, register head addr/data onto cacheWriteAddr/cacheWriteData, set cacheWriteEnable=1, go to BUSY.
  - BUSY: outputs held stable. On cacheWriteDone: pop (rptr+1 mod DEPTH), cacheWriteEnable=0, go to IDLE.
  - The head entry stays valid and forwardable until it is popped.
  - Minimum one idle cycle between consecutive cache writes.
- Simultaneous push and pop: count unchanged; both pointers advance.
- cacheWriteDone while in IDLE: ignored.
- Flush: there is no flush input; ROB resetAll never discards committed stores.
- Ordering: strict FIFO; cache writes leave in commit order.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined:
  - loadFwdHit/loadFwdData are combinational from loadAddr.
  - They compare full-address equality against all valid entries, including the in-flight head.
  - The youngest match wins, scanning from wptr-1 back to rptr.
- Undefined:
  - loadFwdHit is tied to 0 and loadFwdData to 0; no comparators are built.
  - loadRS must stall loads while !empty.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding: SWB_IDLE=0, SWB_BUSY=1.
  - Entry struct {valid, addr, data}.
- Natural sub-module: swb_fifo_mem, holding the storage array, pointers and count.
- Top level keeps the handshake logic, drain FSM and forwarding mux.

Test Plan:
- Reset then single store:
  - Stimulus: robWriteEnable with addr 0x40, data 0xDEADBEEF.
  - Required: robWriteDone pulses 1 cycle after the sampling edge; cacheWriteEnable rises the following cycle with 0x40/0xDEADBEEF.
  - Stimulus: cacheWriteDone pulse.
  - Required: empty=1 next cycle.
- Fill to full:
  - Stimulus: DEPTH=4, cache never acknowledges; commit 5 stores (0x00,0x04,0x08,0x0C,0x10).
  - Required: 4 done pulses, full=1, count=4; the 5th request is held with robWriteDone=0.
  - Stimulus: one cacheWriteDone.
  - Required: the 5th store is accepted; full returns to 1.
- Wrap and ordering:
  - Stimulus: stream 10 stores with random 1–3 cycle cache acknowledge.
  - Required: cache write sequence matches commit sequence exactly; pointers wrap with no loss.
- Forwarding (STORE_FWD_EN):
  - Stimulus: store 0x80←1, then 0x80←2, both queued; loadAddr=0x80.
  - Required: hit=1, data=2.
  - Stimulus: loadAddr=0x84.
  - Required: hit=0.
- Async reset while BUSY:
  - Stimulus: assert reset low between clock edges.
  - Required: cacheWriteEnable=0 and count=0 immediately; a subsequent cacheWriteDone changes nothing.
- Simultaneous push and pop at count=2:
  - Required: count stays 2 and robWriteDone pulses in the same cycle as the pop.
